// File: rtl/imul_req_queue.sv
// imul_req_queue
// ---------------------------------------------------------------------------
// FIFO request queue that sits in front of the iterative integer multiplier.
// Each entry holds one multiply request {a, b}. The producer can keep issuing
// requests while the multiplier is still busy with an earlier one.
// Storage is registered. No combinational path exists from the enq side to
// the deq side. All status outputs are decoded from registered state only.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low; clears pointers and occupancy
//   enq_val   upstream request valid
//   enq_rdy   queue not full (independent of deq_rdy)
//   enq_msg   upstream request {a[63:32], b[31:0]}
//   deq_val   queue not empty
//   deq_rdy   multiplier ready to take the head request
//   deq_msg   head entry (don't-care while empty)
//   num_free  number of empty entries, 0..p_depth
// ---------------------------------------------------------------------------
module imul_req_queue #(
   parameter int p_nbits = 64,
   parameter int p_depth = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enq_val,
   output logic                       enq_rdy,
   input  logic [p_nbits-1:0]         enq_msg,
   output logic                       deq_val,
   input  logic                       deq_rdy,
   output logic [p_nbits-1:0]         deq_msg,
   output logic [$clog2(p_depth):0]   num_free
);

   localparam int c_aw = $clog2(p_depth);
   localparam int c_cw = c_aw + 1;

   localparam logic [c_cw-1:0] c_depth   = c_cw'(p_depth);
   localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

   logic [p_nbits-1:0] storage_q [p_depth];
   logic [p_nbits-1:0] storage_d [p_depth];

   logic [c_aw-1:0] enq_ptr_q, enq_ptr_d;
   logic [c_aw-1:0] deq_ptr_q, deq_ptr_d;
   logic [c_cw-1:0] count_q,   count_d;

   logic full_s;
   logic empty_s;
   logic enq_go_s;
   logic deq_go_s;

   // Status decode from registered occupancy only (Moore outputs).
   always_comb begin
      full_s   = (count_q == c_depth);
      empty_s  = (count_q == {c_cw{1'b0}});
      enq_rdy  = !full_s;
      deq_val  = !empty_s;
      num_free = c_depth - count_q;
      deq_msg  = storage_q[deq_ptr_q];
   end

   // Handshakes, pointer advance and occupancy update.
   always_comb begin
      enq_go_s  = enq_val && enq_rdy;
      deq_go_s  = deq_val && deq_rdy;
      enq_ptr_d = enq_ptr_q;
      deq_ptr_d = deq_ptr_q;
      count_d   = count_q;

      // Pointers wrap modulo p_depth by natural overflow (power-of-two depth).
      if (enq_go_s) begin
         enq_ptr_d = enq_ptr_q + c_ptr_one;
      end else begin
         enq_ptr_d = enq_ptr_q;
      end

      if (deq_go_s) begin
         deq_ptr_d = deq_ptr_q + c_ptr_one;
      end else begin
         deq_ptr_d = deq_ptr_q;
      end

      // Simultaneous enq and deq leaves occupancy unchanged; at count 1 the
      // new entry simply becomes the head because deq_ptr follows enq_ptr.
      case ({enq_go_s, deq_go_s})
         2'b10:   count_d = count_q + c_cnt_one;
         2'b01:   count_d = count_q - c_cnt_one;
         default: count_d = count_q;
      endcase
   end

   // Next storage contents: only an accepted enqueue writes an entry.
   always_comb begin
      storage_d = storage_q;
      if (enq_go_s) begin
         storage_d[enq_ptr_q] = enq_msg;
      end else begin
         storage_d[enq_ptr_q] = storage_q[enq_ptr_q];
      end
   end

   // Control state: cleared immediately on reset, contents of storage are
   // then ignored because count is zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enq_ptr_q <= {c_aw{1'b0}};
         deq_ptr_q <= {c_aw{1'b0}};
         count_q   <= {c_cw{1'b0}};
      end else begin
         enq_ptr_q <= enq_ptr_d;
         deq_ptr_q <= deq_ptr_d;
         count_q   <= count_d;
      end
   end

   // Entry array; no reset needed since unoccupied entries are never read
   // as valid data.
   always_ff @(posedge clk) begin
      storage_q <= storage_d;
   end

endmodule
